// File: rtl/regwb_pkg.sv
// ----------------------------------------------------------------------------
// regwb_pkg
// Shared constants and types for the register-file writeback arbiter.
//   XLEN / AW    : default data width and register address width
//   IDW          : width of the grant index reported to the pipeline
//   REG_ZERO     : architectural zero register (writes are discarded)
//   X0_DROP_MAX  : saturation value of the discarded-x0-write counter
//   wb_req_t     : one writeback request (destination + data)
// ----------------------------------------------------------------------------
package regwb_pkg;

  localparam int XLEN        = 32;
  localparam int AW          = 5;
  localparam int IDW         = 3;
  localparam int REG_ZERO    = 0;
  localparam int X0_DROP_MAX = 255;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal rotating priority pointer.
// The search starts at the pointer and ascends with wrap; the first
// requesting index wins. On a grant to index i the pointer moves to
// (i+1) mod N; with no grant (including while disabled) it stays put.
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   req         : request vector
//   en          : arbitration enable; no grant while low
//   grant       : one-hot grant (all-zero when nothing granted)
//   grant_idx   : index of the granted requester
//   any_grant   : a grant was issued this cycle
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N   = 3,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand;

  // Candidate k is (ptr + k) mod N; the extra bit keeps the sum from
  // wrapping before the explicit modulo subtraction.
  // NOTE: every signal driven here gets a default at the top of the block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (en && !any_grant && req[cand[IW-1:0]]) begin
        any_grant             = 1'b1;
        win_idx               = cand[IW-1:0];
        grant[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

  assign grant_idx = IDW'(win_idx);

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port among N_REQ writeback
// requesters. A round-robin arbiter grants at most one valid requester per
// cycle (combinationally); the winner is captured into a registered write
// stage that drives WE3/A3/WD3 in the following cycle. Writes to x0 complete
// their handshake but never raise rf_we; they are counted in x0_drops.
//
// Optional build macro: REGWB_FWD_EN adds a same-cycle forwarding compare
// against the write in flight (fwd_a1/fwd_a2 -> fwd_hit1/fwd_hit2, fwd_data).
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-requester write request
//   req_addr    : packed destinations, requester i at [i*AW +: AW]
//   req_data    : packed data, requester i at [i*XLEN +: XLEN]
//   req_ready   : one-hot grant, all-zero while reset is high
//   hold        : freezes arbitration (no new grants, pointer unchanged)
//   rf_we/rf_addr/rf_wdata : register file WE3/A3/WD3
//   grant_id    : requester whose write is currently on rf_*
//   x0_drops    : saturating count of discarded x0 writes
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regwb_pkg::IDW;
  import regwb_pkg::REG_ZERO;
  import regwb_pkg::X0_DROP_MAX;
#(
  parameter int N_REQ = 3,
  parameter int XLEN  = regwb_pkg::XLEN,
  parameter int AW    = regwb_pkg::AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  hold,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_addr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [2:0]            grant_id,
  output logic [7:0]            x0_drops
`ifdef REGWB_FWD_EN
  ,
  input  logic [AW-1:0]         fwd_a1,
  input  logic [AW-1:0]         fwd_a2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_grant;

  logic [AW-1:0]    win_addr;
  logic [XLEN-1:0]  win_data;
  logic             win_is_x0;

  logic             rf_we_q,    rf_we_d;
  logic [AW-1:0]    rf_addr_q,  rf_addr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [7:0]       x0_drops_q, x0_drops_d;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (~hold),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The write stage is held in reset too, but the handshake itself must be
  // suppressed while reset is high so no requester believes it was accepted.
  assign req_ready = reset ? '0 : grant;

  // One-hot select of the winner's fields.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign win_is_x0 = (win_addr == AW'(REG_ZERO));

  // Write stage: every grant is captured, but an x0 destination never
  // raises rf_we. Without a grant, address/data keep their last values.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    x0_drops_d = x0_drops_q;
    if (any_grant) begin
      rf_we_d    = !win_is_x0;
      rf_addr_d  = win_addr;
      rf_wdata_d = win_data;
      grant_id_d = grant_idx;
      if (win_is_x0 && (x0_drops_q != 8'(X0_DROP_MAX))) begin
        x0_drops_d = x0_drops_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      x0_drops_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      x0_drops_q <= x0_drops_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = 3'(grant_id_q);
  assign x0_drops = x0_drops_q;

`ifdef REGWB_FWD_EN
  // Bypass for a decode-stage read of the register being written this
  // cycle; x0 reads always return zero so they never hit.
  assign fwd_hit1 = rf_we_q && (rf_addr_q == fwd_a1) && (fwd_a1 != AW'(REG_ZERO));
  assign fwd_hit2 = rf_we_q && (rf_addr_q == fwd_a2) && (fwd_a2 != AW'(REG_ZERO));
  assign fwd_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (N_REQ=3, XLEN=32, AW=5) with a
// small register file model attached to the write port. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  import regwb_pkg::wb_req_t;

  localparam int N_REQ = 3;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_addr;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  hold;
  logic                  rf_we;
  logic [AW-1:0]         rf_addr;
  logic [XLEN-1:0]       rf_wdata;
  logic [2:0]            grant_id;
  logic [7:0]            x0_drops;
`ifdef REGWB_FWD_EN
  logic [AW-1:0]         fwd_a1, fwd_a2;
  logic                  fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]       fwd_data;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Register file model without a hardwired x0: only the arbiter's filter
  // keeps x0 at zero.
  logic [XLEN-1:0] rf_mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  end

  regfile_wb_arbiter #(
    .N_REQ (N_REQ),
    .XLEN  (XLEN),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .x0_drops  (x0_drops)
`ifdef REGWB_FWD_EN
    ,
    .fwd_a1    (fwd_a1),
    .fwd_a2    (fwd_a2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input wb_req_t r);
    req_addr[i*AW +: AW]     = r.addr;
    req_data[i*XLEN +: XLEN] = r.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int we_seen;

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef REGWB_FWD_EN
    fwd_a1 = '0;
    fwd_a2 = '0;
`endif

    // Handshake suppressed during reset even with every requester valid.
    req_valid = 3'b111;
    #12;
    check("ready_in_reset", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();
    reset = 1'b0;

    // 1: idle after reset.
    check("reset_addr", 64'(rf_addr), 64'd0);
    check("reset_wdata", 64'(rf_wdata), 64'd0);
    check("reset_grant_id", 64'(grant_id), 64'd0);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("idle_c%0d", c), 64'({rf_we, req_ready, x0_drops}), 64'd0);
      tick();
    end

    // 2: single write by requester 1, pointer 0 -> grant 1, pointer -> 2.
    set_req(1, '{addr: 5'd5, data: 32'hDEADBEEF});
    req_valid = 3'b010;
    #1;
    check("single_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    check("single_we", 64'(rf_we), 64'd1);
    check("single_addr", 64'(rf_addr), 64'd5);
    check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("single_gid", 64'(grant_id), 64'd1);
    tick();
    check("single_commit_x5", 64'(rf_mem[5]), 64'hDEADBEEF);
    check("single_we_drop", 64'(rf_we), 64'd0);

    // Requester 2 alone: pointer 2 -> grant 2 -> pointer back to 0.
    set_req(2, '{addr: 5'd9, data: 32'h0000_0099});
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    check("realign_gid", 64'(grant_id), 64'd2);
    tick();

    // 3: all three valid continuously -> 0,1,2,0,1,2.
    set_req(0, '{addr: 5'd1, data: 32'h1111_0000});
    set_req(1, '{addr: 5'd2, data: 32'h2222_0000});
    set_req(2, '{addr: 5'd3, data: 32'h3333_0000});
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      tick();
      check($sformatf("rr_we_c%0d", c), 64'(rf_we), 64'd1);
      check($sformatf("rr_gid_c%0d", c), 64'(grant_id), 64'(c % 3));
      check($sformatf("rr_addr_c%0d", c), 64'(rf_addr), 64'((c % 3) + 1));
    end
    req_valid = '0;
    tick();
    check("rr_commit_x3", 64'(rf_mem[3]), 64'h3333_0000);

    // 4: x0 write is accepted but filtered.
    set_req(0, '{addr: 5'd0, data: 32'h0000_1234});
    req_valid = 3'b001;
    #1;
    check("x0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_drops_1", 64'(x0_drops), 64'd1);
    tick();
    check("x0_reads_zero", 64'(rf_mem[0]), 64'd0);

    // 254 more -> 255, then 46 more -> stays saturated.
    req_valid = 3'b001;
    we_seen   = 0;
    for (int c = 0; c < 254; c++) begin
      tick();
      if (rf_we) we_seen++;
    end
    check("x0_drops_255", 64'(x0_drops), 64'd255);
    for (int c = 0; c < 46; c++) begin
      tick();
      if (rf_we) we_seen++;
    end
    req_valid = '0;
    check("x0_drops_sat", 64'(x0_drops), 64'd255);
    check("x0_no_we", 64'(we_seen), 64'd0);
    tick();
    check("x0_still_zero", 64'(rf_mem[0]), 64'd0);

    // 5: pointer is 1; grant requester 2 to bring it to 0, then hold.
    set_req(2, '{addr: 5'd4, data: 32'h0000_0444});
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    tick();
    set_req(0, '{addr: 5'd10, data: 32'h0A0A_0A0A});
    hold      = 1'b1;
    req_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("hold_ready_c%0d", c), 64'(req_ready), 64'd0);
      check($sformatf("hold_we_c%0d", c), 64'(rf_we), 64'd0);
      tick();
    end
    hold = 1'b0;
    #1;
    check("unhold_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("unhold_we", 64'(rf_we), 64'd1);
    check("unhold_gid", 64'(grant_id), 64'd0);
    check("unhold_addr", 64'(rf_addr), 64'd10);
    tick();

    // 6: reset while a write is in flight; pointer (now 2) returns to 0.
    set_req(1, '{addr: 5'd6, data: 32'h0000_0666});
    req_valid = 3'b010;
    tick();
    req_valid = 3'b111;
    check("pre_reset_we", 64'(rf_we), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("reset_we_drop", 64'(rf_we), 64'd0);
    check("reset_addr_clr", 64'(rf_addr), 64'd0);
    check("reset_ready_off", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("reset_ptr_zero", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("post_reset_gid", 64'(grant_id), 64'd0);
    check("no_stale_x6", 64'(rf_mem[6]), 64'd0);
    tick();

`ifdef REGWB_FWD_EN
    set_req(0, '{addr: 5'd7, data: 32'hA5A5A5A5});
    req_valid = 3'b001;
    fwd_a1    = 5'd7;
    fwd_a2    = 5'd0;
    tick();
    req_valid = '0;
    #1;
    check("fwd_hit1", 64'(fwd_hit1), 64'd1);
    check("fwd_data", 64'(fwd_data), 64'hA5A5A5A5);
    check("fwd_hit2_x0", 64'(fwd_hit2), 64'd0);
    fwd_a1 = 5'd0;
    fwd_a2 = 5'd7;
    #1;
    check("fwd_hit1_x0", 64'(fwd_hit1), 64'd0);
    check("fwd_hit2", 64'(fwd_hit2), 64'd1);
    tick();
    check("fwd_no_we", 64'(fwd_hit2), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
